// File: rtl/request_issuer_pkg.sv
// request_issuer_pkg: shared types, widths and helpers for request_issuer.
//   ADDR_W / ID_W   : taken from `ADDRESS_WIDTH / `ID_WIDTH (normally defines.vh)
//   NUM_IDS         : size of the transaction ID space
//   STATUS_*_BIT    : issuer-status field layout for CSR export
//   lowest_free()   : priority encoder returning the lowest non-busy ID
// Optional feature macro used by the block: REQUEST_ISSUER_TIMEOUT_EN.
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 32
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 3
`endif

package request_issuer_pkg;
    localparam int unsigned ADDR_W  = `ADDRESS_WIDTH;
    localparam int unsigned ID_W    = `ID_WIDTH;
    localparam int unsigned NUM_IDS = 1 << ID_W;

    localparam int unsigned STATUS_ERR_CPL_BIT     = 0;
    localparam int unsigned STATUS_ERR_TIMEOUT_BIT = 1;

    typedef logic [ID_W-1:0]    id_t;
    typedef logic [NUM_IDS-1:0] id_mask_t;

    typedef struct packed {
        logic found;
        id_t  id;
    } alloc_t;

    // Scan from the top down so the lowest free index is the last one written.
    function automatic alloc_t lowest_free(input id_mask_t busy);
        alloc_t r;
        r.found = 1'b0;
        r.id    = '0;
        for (int unsigned i = NUM_IDS; i > 0; i--) begin
            if (!busy[i-1]) begin
                r.found = 1'b1;
                r.id    = id_t'(i - 1);
            end
        end
        return r;
    endfunction
endpackage

// File: rtl/request_issuer_id_alloc.sv
// request_issuer_id_alloc: transaction ID bookkeeping.
//   clk, reset   : clock, synchronous active-high reset
//   alloc_en     : take alloc_id this cycle (marks it busy)
//   cpl_valid/id : completion strobe and ID; clears busy if the ID is in flight
//   free_avail   : at least one ID is not busy
//   alloc_id     : lowest non-busy ID from the registered busy vector
//   outstanding  : number of busy IDs
//   cpl_bad      : completion this cycle names an ID that is not busy
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 32
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 3
`endif

module request_issuer_id_alloc
    import request_issuer_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 8,
    parameter int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alloc_en,
    input  logic             cpl_valid,
    input  id_t              cpl_id,
    output logic             free_avail,
    output id_t              alloc_id,
    output logic [CNT_W-1:0] outstanding,
    output logic             cpl_bad
);
    id_mask_t busy;
    id_mask_t set_mask;
    id_mask_t clr_mask;
    alloc_t   pick;
    logic     cpl_hit;

    assign pick       = lowest_free(busy);
    assign free_avail = pick.found;
    assign alloc_id   = pick.id;
    assign cpl_hit    = cpl_valid & busy[cpl_id];
    assign cpl_bad    = cpl_valid & ~busy[cpl_id];

    // The allocated ID is never busy and a hit completion always is, so the
    // set and clear masks can never target the same bit.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (alloc_en) set_mask[alloc_id] = 1'b1;
        if (cpl_hit)  clr_mask[cpl_id]   = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy        <= '0;
            outstanding <= '0;
        end else begin
            busy <= (busy | set_mask) & ~clr_mask;
            unique case ({alloc_en, cpl_hit})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end
endmodule

// File: rtl/request_issuer.sv
// request_issuer: head-of-pipeline initiator. Tags client commands with a free
// transaction ID, drives them through a single output register that honours
// the pipeline stall, and retires completion IDs from the pipeline tail.
//   clk, reset             : clock, synchronous active-high reset
//   cmd_address/valid/ready: client command handshake
//   out_address/id/valid   : request into the pipeline; transfer when !in_stall
//   in_stall               : pipeline backpressure
//   cpl_id/cpl_valid       : completion return, always accepted
//   outstanding            : IDs allocated and not yet completed
//   err_cpl                : sticky, completion for a non-busy ID
//   err_timeout            : sticky watchdog flag
// Optional feature: define REQUEST_ISSUER_TIMEOUT_EN to build the watchdog;
// otherwise err_timeout is tied 0.
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 32
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 3
`endif

module request_issuer
    import request_issuer_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 8,
    parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [`ADDRESS_WIDTH-1:0]            cmd_address,
    input  logic                                 cmd_valid,
    output logic                                 cmd_ready,
    output logic [`ADDRESS_WIDTH-1:0]            out_address,
    output logic [`ID_WIDTH-1:0]                 out_id,
    output logic                                 out_valid,
    input  logic                                 in_stall,
    input  logic [`ID_WIDTH-1:0]                 cpl_id,
    input  logic                                 cpl_valid,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
    output logic                                 err_cpl,
    output logic                                 err_timeout
);
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > NUM_IDS || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("request_issuer: invalid MAX_OUTSTANDING or TIMEOUT_CYCLES");
    end

    logic can_load;
    logic accept;
    logic free_avail;
    id_t  alloc_id;
    logic cpl_bad;

    assign can_load  = ~out_valid | ~in_stall;
    assign cmd_ready = can_load & free_avail & (outstanding < CNT_W'(MAX_OUTSTANDING));
    assign accept    = cmd_valid & cmd_ready;

    request_issuer_id_alloc #(
        .MAX_OUTSTANDING(MAX_OUTSTANDING),
        .CNT_W          (CNT_W)
    ) u_id_alloc (
        .clk        (clk),
        .reset      (reset),
        .alloc_en   (accept),
        .cpl_valid  (cpl_valid),
        .cpl_id     (cpl_id),
        .free_avail (free_avail),
        .alloc_id   (alloc_id),
        .outstanding(outstanding),
        .cpl_bad    (cpl_bad)
    );

    // Address and ID only move on a new load; an emptied register keeps them.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_address <= '0;
            out_id      <= '0;
        end else if (can_load) begin
            if (accept) begin
                out_address <= cmd_address;
                out_id      <= alloc_id;
                out_valid   <= 1'b1;
            end else begin
                out_valid   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) err_cpl <= 1'b0;
        else if (cpl_bad) err_cpl <= 1'b1;
    end

`ifdef REQUEST_ISSUER_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt;
    logic [WD_W-1:0] wd_next;

    always_comb begin
        wd_next = wd_cnt;
        if (cpl_valid || outstanding == '0) wd_next = '0;
        else if (wd_cnt != WD_W'(TIMEOUT_CYCLES)) wd_next = wd_cnt + WD_W'(1);
    end

    // Flag on the cycle the count reaches the threshold, then saturate.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt      <= '0;
            err_timeout <= 1'b0;
        end else begin
            wd_cnt <= wd_next;
            if (wd_next == WD_W'(TIMEOUT_CYCLES)) err_timeout <= 1'b1;
        end
    end
`else
    assign err_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_request_issuer.sv
// tb_request_issuer: directed, table-driven bench for request_issuer plus
// hand-written sequences for capacity, same-cycle accept/completion, error
// and reset corners (and the watchdog when REQUEST_ISSUER_TIMEOUT_EN is set).
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 32
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 3
`endif

module tb_request_issuer;
    localparam int AW = `ADDRESS_WIDTH;
    localparam int IW = `ID_WIDTH;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] cmd_address = '0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] out_address;
    logic [IW-1:0] out_id;
    logic          out_valid;
    logic          in_stall = 1'b0;
    logic [IW-1:0] cpl_id = '0;
    logic          cpl_valid = 1'b0;
    logic [3:0]    outstanding;
    logic          err_cpl;
    logic          err_timeout;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    request_issuer #(
        .MAX_OUTSTANDING(8),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_address(cmd_address),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .out_address(out_address),
        .out_id     (out_id),
        .out_valid  (out_valid),
        .in_stall   (in_stall),
        .cpl_id     (cpl_id),
        .cpl_valid  (cpl_valid),
        .outstanding(outstanding),
        .err_cpl    (err_cpl),
        .err_timeout(err_timeout)
    );

    typedef struct {
        logic          cv;
        logic [AW-1:0] addr;
        logic          st;
        logic          pv;
        logic [IW-1:0] pid;
        logic          e_rdy;
        logic          e_ov;
        logic [IW-1:0] e_id;
        logic [AW-1:0] e_addr;
        logic [3:0]    e_out;
        logic          e_err;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs[NV];

    function automatic vec_t mk(logic cv, logic [AW-1:0] addr, logic st, logic pv,
                                logic [IW-1:0] pid, logic e_rdy, logic e_ov,
                                logic [IW-1:0] e_id, logic [AW-1:0] e_addr,
                                logic [3:0] e_out, logic e_err);
        vec_t v;
        v.cv = cv; v.addr = addr; v.st = st; v.pv = pv; v.pid = pid;
        v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_id = e_id; v.e_addr = e_addr;
        v.e_out = e_out; v.e_err = e_err;
        return v;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; cmd_valid = 1'b0; cpl_valid = 1'b0; in_stall = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        // cv addr st pv pid | rdy ov id addr out err  (expected before the edge)
        vecs[0]  = mk(1, 'h10, 0, 0, 0, 1, 0, 0, 'h00, 0, 0);
        vecs[1]  = mk(0, 'h00, 0, 0, 0, 1, 1, 0, 'h10, 1, 0);
        vecs[2]  = mk(1, 'h20, 0, 0, 0, 1, 0, 0, 'h10, 1, 0);
        vecs[3]  = mk(1, 'h30, 1, 0, 0, 0, 1, 1, 'h20, 2, 0);
        vecs[4]  = mk(1, 'h30, 1, 0, 0, 0, 1, 1, 'h20, 2, 0);
        vecs[5]  = mk(1, 'h30, 1, 0, 0, 0, 1, 1, 'h20, 2, 0);
        vecs[6]  = mk(1, 'h30, 1, 0, 0, 0, 1, 1, 'h20, 2, 0);
        vecs[7]  = mk(1, 'h30, 1, 0, 0, 0, 1, 1, 'h20, 2, 0);
        vecs[8]  = mk(1, 'h30, 0, 0, 0, 1, 1, 1, 'h20, 2, 0);
        vecs[9]  = mk(0, 'h00, 0, 0, 0, 1, 1, 2, 'h30, 3, 0);
        vecs[10] = mk(0, 'h00, 0, 1, 1, 1, 0, 2, 'h30, 3, 0);
        vecs[11] = mk(0, 'h00, 0, 0, 0, 1, 0, 2, 'h30, 2, 0);
        vecs[12] = mk(1, 'h40, 0, 0, 0, 1, 0, 2, 'h30, 2, 0);
        vecs[13] = mk(0, 'h00, 0, 1, 5, 1, 1, 1, 'h40, 3, 0);
        vecs[14] = mk(0, 'h00, 0, 0, 0, 1, 0, 1, 'h40, 3, 1);
        vecs[15] = mk(0, 'h00, 0, 1, 2, 1, 0, 1, 'h40, 3, 1);
        vecs[16] = mk(0, 'h00, 0, 0, 0, 1, 0, 1, 'h40, 2, 1);

        do_reset();
        check("rst_out_valid", 64'(out_valid), 0);
        check("rst_out_addr", 64'(out_address), 0);
        check("rst_out_id", 64'(out_id), 0);
        check("rst_outstanding", 64'(outstanding), 0);
        check("rst_err_cpl", 64'(err_cpl), 0);
        check("rst_err_timeout", 64'(err_timeout), 0);

        for (int i = 0; i < NV; i++) begin
            cmd_valid = vecs[i].cv; cmd_address = vecs[i].addr; in_stall = vecs[i].st;
            cpl_valid = vecs[i].pv; cpl_id = vecs[i].pid;
            #1;
            check($sformatf("v%0d_cmd_ready", i), 64'(cmd_ready), 64'(vecs[i].e_rdy));
            check($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].e_ov));
            check($sformatf("v%0d_out_id", i), 64'(out_id), 64'(vecs[i].e_id));
            check($sformatf("v%0d_out_addr", i), 64'(out_address), 64'(vecs[i].e_addr));
            check($sformatf("v%0d_outstanding", i), 64'(outstanding), 64'(vecs[i].e_out));
            check($sformatf("v%0d_err_cpl", i), 64'(err_cpl), 64'(vecs[i].e_err));
            tick();
        end
        cmd_valid = 1'b0; cpl_valid = 1'b0;

        // Fill all 8 IDs back-to-back, then retire ID 3 at the limit.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cmd_valid = 1'b1; cmd_address = AW'(32'h100 + i);
            #1;
            check($sformatf("fill%0d_ready", i), 64'(cmd_ready), 1);
            tick();
            check($sformatf("fill%0d_id", i), 64'(out_id), 64'(i));
            check($sformatf("fill%0d_valid", i), 64'(out_valid), 1);
            check($sformatf("fill%0d_outstanding", i), 64'(outstanding), 64'(i + 1));
        end
        #1;
        check("full_ready", 64'(cmd_ready), 0);
        cpl_valid = 1'b1; cpl_id = 3;
        #1;
        check("full_ready_during_cpl", 64'(cmd_ready), 0);
        tick();
        cpl_valid = 1'b0; cmd_address = 'h200;
        #1;
        check("after_cpl_outstanding", 64'(outstanding), 7);
        check("after_cpl_ready", 64'(cmd_ready), 1);
        tick();
        check("reuse_id", 64'(out_id), 3);
        check("reuse_addr", 64'(out_address), 'h200);
        check("reuse_outstanding", 64'(outstanding), 8);
        #1;
        check("refull_ready", 64'(cmd_ready), 0);

        // Reset while busy forgets everything.
        cmd_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_valid", 64'(out_valid), 0);
        check("midrst_outstanding", 64'(outstanding), 0);
        check("midrst_id", 64'(out_id), 0);
        check("midrst_addr", 64'(out_address), 0);

        // Same-cycle accept and completion with 4 outstanding.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cmd_valid = 1'b1; cmd_address = AW'(32'h300 + i);
            tick();
        end
        cmd_address = 'h3A0; cpl_valid = 1'b1; cpl_id = 0;
        #1;
        check("same_pre_outstanding", 64'(outstanding), 4);
        check("same_ready", 64'(cmd_ready), 1);
        tick();
        cpl_valid = 1'b0;
        check("same_outstanding", 64'(outstanding), 4);
        check("same_alloc_id", 64'(out_id), 4);
        cmd_address = 'h3B0;
        tick();
        cmd_valid = 1'b0;
        check("freed0_id", 64'(out_id), 0);
        check("freed0_outstanding", 64'(outstanding), 5);

        // Completion for a non-busy ID is flagged and sticky.
        cpl_valid = 1'b1; cpl_id = 5;
        tick();
        cpl_valid = 1'b0;
        check("bad_cpl_err", 64'(err_cpl), 1);
        check("bad_cpl_outstanding", 64'(outstanding), 5);
        tick();
        check("bad_cpl_sticky", 64'(err_cpl), 1);
        do_reset();
        check("bad_cpl_cleared", 64'(err_cpl), 0);

`ifdef REQUEST_ISSUER_TIMEOUT_EN
        // One request with no completion: flag rises 16 cycles after accept.
        cmd_valid = 1'b1; cmd_address = 'h500;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        check("wd_not_yet", 64'(err_timeout), 0);
        tick();
        check("wd_fired", 64'(err_timeout), 1);
        for (int i = 0; i < 4; i++) tick();
        check("wd_sticky", 64'(err_timeout), 1);

        // Completion at cycle 10 keeps the flag clear.
        do_reset();
        cmd_valid = 1'b1; cmd_address = 'h600;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        cpl_valid = 1'b1; cpl_id = 0;
        tick();
        cpl_valid = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check("wd_quiet", 64'(err_timeout), 0);
`else
        // Watchdog absent: flag stays 0 even with a long-held request.
        cmd_valid = 1'b1; cmd_address = 'h500;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 40; i++) tick();
        check("wd_absent_outstanding", 64'(outstanding), 1);
        check("wd_absent", 64'(err_timeout), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
